// File: rtl/kypd_pkg.sv
// Shared types and key-map helpers for the 4x4 Pmod keypad emulator.
package kypd_pkg;

  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;

  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } cr_t;

  // Both column strobes and row patterns use the same single-zero encoding.
  function automatic logic [3:0] one_zero(input logic [1:0] idx);
    case (idx)
      2'd0:    return COL0;
      2'd1:    return COL1;
      2'd2:    return COL2;
      default: return COL3;
    endcase
  endfunction

  function automatic cr_t key_to_cr(input logic [3:0] code);
    cr_t cr;
    case (code)
      4'h1:    cr = {2'd0, 2'd0};
      4'h4:    cr = {2'd0, 2'd1};
      4'h7:    cr = {2'd0, 2'd2};
      4'h0:    cr = {2'd0, 2'd3};
      4'h2:    cr = {2'd1, 2'd0};
      4'h5:    cr = {2'd1, 2'd1};
      4'h8:    cr = {2'd1, 2'd2};
      4'hF:    cr = {2'd1, 2'd3};
      4'h3:    cr = {2'd2, 2'd0};
      4'h6:    cr = {2'd2, 2'd1};
      4'h9:    cr = {2'd2, 2'd2};
      4'hE:    cr = {2'd2, 2'd3};
      4'hA:    cr = {2'd3, 2'd0};
      4'hB:    cr = {2'd3, 2'd1};
      4'hC:    cr = {2'd3, 2'd2};
      default: cr = {2'd3, 2'd3};
    endcase
    return cr;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding pending key codes; the read word is visible
// combinationally at the head so the FSM can pop and load in one edge.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Press side of the 4x4 Pmod keypad: queues key codes, presses each one for a
// programmed time and answers the decoder's column strobes with row patterns.
module keypad_emulator
  import kypd_pkg::*;
#(
  parameter int HOLD_CYCLES   = 500_000,
  parameter int GAP_CYCLES    = 500_000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int DEPTH         = 4
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       busy
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] BOUNCE_LAST = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HOLD_LAST   = CW'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_CYCLES    > 0) ? GAP_CYCLES    - 1 : 0);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pressed_next;
  logic          pop;
  logic [3:0]    head_key;
  logic [3:0]    active_key;
  logic          full, empty;
  cr_t           key_cr;

  key_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
    .clock     (clock_100Mhz),
    .reset     (reset),
    .push      (key_valid && key_ready),
    .push_data (key_code),
    .pop       (pop),
    .pop_data  (head_key),
    .full      (full),
    .empty     (empty)
  );

  assign key_ready = !full;
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pressed    <= 1'b0;
      active_key <= 4'h0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pressed <= pressed_next;
      if (pop) active_key <= head_key;
    end
  end

  // pressed is registered from the next state, so it changes on the same edge
  // as the state that defines it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          state_next = (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
        end
      end
      BOUNCE: if (cnt == BOUNCE_LAST) begin
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: if (cnt == HOLD_LAST) begin
        state_next = GAP;
        cnt_next   = '0;
      end
      GAP: if (cnt == GAP_LAST) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    pressed_next = (state_next == HOLD) || ((state_next == BOUNCE) && !cnt_next[0]);
  end

  assign key_cr = key_to_cr(active_key);

  always_comb begin
    row = 4'b1111;
    if (pressed && (col == one_zero(key_cr.col))) row = one_zero(key_cr.row);
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench: two emulators (no chatter / 4-cycle chatter) against a
// timeline model of queued presses.
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int G = 10;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] kc      [2];
  logic       kv      [2];
  logic [3:0] col     [2];
  logic       ready   [2];
  logic       pressed [2];
  logic       busy    [2];
  logic [3:0] row     [2];

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(0), .DEPTH(D)) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .key_code     (kc[0]),
    .key_valid    (kv[0]),
    .key_ready    (ready[0]),
    .col          (col[0]),
    .row          (row[0]),
    .pressed      (pressed[0]),
    .busy         (busy[0])
  );

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(4), .DEPTH(D)) dut_bounce (
    .clock_100Mhz (clk),
    .reset        (rst),
    .key_code     (kc[1]),
    .key_valid    (kv[1]),
    .key_ready    (ready[1]),
    .col          (col[1]),
    .row          (row[1]),
    .pressed      (pressed[1]),
    .busy         (busy[1])
  );

  // Key map as printed on the keypad: strobe and row pattern per key code.
  logic [3:0] kmap_col [16] = '{4'b0111, 4'b0111, 4'b1011, 4'b1101,
                                4'b0111, 4'b1011, 4'b1101, 4'b0111,
                                4'b1011, 4'b1101, 4'b1110, 4'b1110,
                                4'b1110, 4'b1110, 4'b1101, 4'b1011};
  logic [3:0] kmap_row [16] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111,
                                4'b1011, 4'b1011, 4'b1011, 4'b1101,
                                4'b1101, 4'b1101, 4'b0111, 4'b1011,
                                4'b1101, 4'b1110, 4'b1110, 4'b1110};
  logic [3:0] strobes  [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  int         bnc [2] = '{0, 4};
  logic [3:0] mq0 [$];
  logic [3:0] mq1 [$];
  bit         act [2];
  logic [3:0] ak  [2];
  int         st  [2];
  bit         acc [2];
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [3:0] qpop(input int i);
    if (i == 0) return mq0.pop_front();
    return mq1.pop_front();
  endfunction

  function automatic void qpush(input int i, input logic [3:0] k);
    if (i == 0) mq0.push_back(k);
    else        mq1.push_back(k);
  endfunction

  // Each press occupies bounce+hold pressed cycles, then gap released cycles.
  function automatic bit exp_pressed(input int i);
    int d;
    if (!act[i]) return 1'b0;
    d = cyc - st[i];
    if (d < bnc[i]) return (d % 2) == 0;
    return d < bnc[i] + H;
  endfunction

  function automatic bit exp_busy(input int i);
    if (qsize(i) > 0) return 1'b1;
    if (!act[i])      return 1'b0;
    return (cyc - st[i]) < bnc[i] + H + G;
  endfunction

  function automatic logic [3:0] exp_row(input int i);
    if (exp_pressed(i) && col[i] === kmap_col[ak[i]]) return kmap_row[ak[i]];
    return 4'hF;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("pressed%0d@%0d", i, cyc), 32'(pressed[i]), 32'(exp_pressed(i)));
      check_output($sformatf("busy%0d@%0d", i, cyc),    32'(busy[i]),    32'(exp_busy(i)));
      check_output($sformatf("ready%0d@%0d", i, cyc),   32'(ready[i]),   32'(qsize(i) < D));
      check_output($sformatf("row%0d@%0d", i, cyc),     32'(row[i]),     32'(exp_row(i)));
    end
  endtask

  // A key leaves the queue on the first edge after the previous key's gap ends.
  task automatic tick();
    int sz [2];
    for (int i = 0; i < 2; i++) begin
      sz[i]  = qsize(i);
      acc[i] = kv[i] && (sz[i] < D);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (sz[i] > 0 && (!act[i] || (cyc - st[i]) >= bnc[i] + H + G + 1)) begin
        ak[i]  = qpop(i);
        act[i] = 1'b1;
        st[i]  = cyc;
      end
      if (acc[i]) qpush(i, kc[i]);
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push_key(input int i, input logic [3:0] code, output int edge_no);
    kc[i]   = code;
    kv[i]   = 1'b1;
    edge_no = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (acc[i]) begin
        edge_no = cyc;
        break;
      end
    end
    kv[i] = 1'b0;
    if (edge_no < 0) check_output("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((exp_busy(i) || busy[i]) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check_output("idle_timeout", 32'(busy[i]), 32'd0);
  endtask

  task automatic identify(output int key);
    key = -1;
    for (int s = 0; s < 4; s++) begin
      col[0] = strobes[s];
      #1;
      if (row[0] !== 4'hF)
        for (int k = 0; k < 16; k++)
          if (kmap_col[k] === strobes[s] && kmap_row[k] === row[0]) key = k;
    end
  endtask

  task automatic do_reset();
    kv[0] = 1'b0;
    kv[1] = 1'b0;
    rst   = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("rst_pressed%0d", i), 32'(pressed[i]), 32'd0);
      check_output($sformatf("rst_row%0d", i),     32'(row[i]),     32'hF);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq0.delete();
    mq1.delete();
    act[0] = 1'b0;
    act[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("post_rst_busy%0d", i),  32'(busy[i]),  32'd0);
      check_output($sformatf("post_rst_ready%0d", i), 32'(ready[i]), 32'd1);
    end
  endtask

  task automatic apply_stimulus();
    int pe, first_on, last_on, busy_low, hits, key, nacc, prev;
    int acc_edge [7];
    logic [3:0] hit_col, hit_row;
    int order [$];

    // Single press of 0x5 with its column strobe held.
    col[0] = 4'b1011;
    push_key(0, 4'h5, pe);
    first_on = -1; last_on = -1; busy_low = -1;
    for (int n = 0; n < 45; n++) begin
      tick();
      if (row[0] === 4'b1011) begin
        if (first_on < 0) first_on = cyc - pe;
        last_on = cyc - pe;
      end
      if (busy_low < 0 && busy[0] === 1'b0) busy_low = cyc - pe;
    end
    check_output("single_first_row", 32'(first_on), 32'd1);
    check_output("single_last_row",  32'(last_on),  32'd20);
    check_output("single_busy_low",  32'(busy_low), 32'd31);

    // Invalid strobes with 0x7 held.
    push_key(0, 4'h7, pe);
    run(3);
    col[0] = 4'b1111; #1; check_output("inv_1111", 32'(row[0]), 32'hF);
    col[0] = 4'b0101; #1; check_output("inv_0101", 32'(row[0]), 32'hF);
    col[0] = 4'b0000; #1; check_output("inv_0000", 32'(row[0]), 32'hF);
    col[0] = 4'b0111; #1; check_output("inv_0111", 32'(row[0]), 32'hD);
    wait_idle(0);

    // Full key map: exactly one strobe answers per key.
    for (int k = 0; k < 16; k++) begin
      push_key(0, 4'(k), pe);
      run(4);
      hits = 0; hit_col = 4'hF; hit_row = 4'hF;
      for (int s = 0; s < 4; s++) begin
        col[0] = strobes[s];
        #1;
        check_output($sformatf("map_row_k%0h_s%0d", k, s), 32'(row[0]), 32'(exp_row(0)));
        if (row[0] !== 4'hF) begin
          hits++;
          hit_col = strobes[s];
          hit_row = row[0];
        end
      end
      check_output($sformatf("map_hits_k%0h", k), 32'(hits),    32'd1);
      check_output($sformatf("map_col_k%0h", k),  32'(hit_col), 32'(kmap_col[k]));
      check_output($sformatf("map_pat_k%0h", k),  32'(hit_row), 32'(kmap_row[k]));
      wait_idle(0);
    end

    // Backpressure: six keys back to back, queue holds four.
    nacc = 0; prev = 0;
    kc[0] = 4'h1; kv[0] = 1'b1;
    for (int n = 0; n < 400 && (nacc < 6 || exp_busy(0)); n++) begin
      tick();
      if (acc[0]) begin
        nacc++;
        acc_edge[nacc] = cyc;
        if (nacc == 5) check_output("bp_ready_after5", 32'(ready[0]), 32'd0);
        if (nacc < 6) kc[0] = 4'(nacc + 1);
        else          kv[0] = 1'b0;
      end
      if (pressed[0] === 1'b1 && prev == 0) begin
        identify(key);
        order.push_back(key);
      end
      prev = int'(pressed[0] === 1'b1);
    end
    kv[0] = 1'b0;
    check_output("bp_accepts", 32'(nacc), 32'd6);
    if (nacc == 6) check_output("bp_sixth_edge", 32'(acc_edge[6] - acc_edge[1]), 32'(H + G + 3));
    check_output("bp_order_len", 32'(order.size()), 32'd6);
    foreach (order[j]) check_output($sformatf("bp_order%0d", j), 32'(order[j]), 32'(j + 1));

    // Chatter at the start of a press.
    push_key(1, 4'h1, pe);
    for (int j = 0; j < 25; j++) begin
      tick();
      check_output($sformatf("bounce%0d", j), 32'(pressed[1]),
                   32'((j < 4) ? ((j % 2) == 0) : (j < 24)));
    end
    wait_idle(1);

    // Random traffic on both instances, including mid-cycle strobe changes.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        kv[i]  = ($urandom_range(0, 7) == 0);
        kc[i]  = 4'($urandom);
        col[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : strobes[$urandom_range(0, 3)];
      end
      tick();
      col[0] = strobes[$urandom_range(0, 3)];
      #1;
      check_output($sformatf("rand_midrow@%0d", cyc), 32'(row[0]), 32'(exp_row(0)));
    end
    kv[0] = 1'b0;
    kv[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    // Reset in HOLD with two keys still queued.
    push_key(0, 4'h9, pe);
    push_key(0, 4'h2, pe);
    push_key(0, 4'h3, pe);
    col[0] = 4'b1101;
    tick();
    check_output("rst_pre_row", 32'(row[0]), 32'hD);
    do_reset();
    for (int n = 0; n < 40; n++) begin
      tick();
      check_output($sformatf("rst_after_pressed%0d", n), 32'(pressed[0]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      kc[i]  = 4'h0;
      kv[i]  = 1'b0;
      col[i] = 4'hF;
      act[i] = 1'b0;
      ak[i]  = 4'h0;
      st[i]  = 0;
      acc[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("init_pressed%0d", i), 32'(pressed[i]), 32'd0);
      check_output($sformatf("init_row%0d", i),     32'(row[i]),     32'hF);
      check_output($sformatf("init_busy%0d", i),    32'(busy[i]),    32'd0);
      check_output($sformatf("init_ready%0d", i),   32'(ready[i]),   32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
